// File: rtl/sram_like_axi_bridge_pkg.sv
// Shared definitions for the sram-like to AXI bridge family: FSM state
// encoding, fixed AXI field values and sram-like size encodings.
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // The core may issue size 3; the 32-bit bus can only do a word.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SIZE_W : size;
  endfunction

endpackage

// File: rtl/sram_like_axi_bridge_if.sv
// Bus interfaces for the bridge: the core-side sram-like port and a
// single-ID AXI3/AXI4 port. "master" drives requests, "slave" responds.
interface sram_like_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

interface axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]          arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [3:0]          rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic [3:0]          awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [3:0]          wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [3:0]          bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_like_axi_bridge_wstrb.sv
// Byte-lane strobe generator for a 32-bit bus: maps access size and the
// low address bits to the lanes touched. Shared with the instruction bridge.
module wstrb_gen
  import bridge_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_wstrb
);

  // Lane selection; size 3 falls into the word case.
  always_comb begin
    case (i_size)
      SIZE_B:  o_wstrb = 4'b0001 << i_addr_lo;
      SIZE_H:  o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
      default: o_wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_like_axi_bridge.sv
// Responder for the core's sram-like data port. Each accepted request
// becomes one single-beat AXI read or write; one transaction in flight.
// Optional build macro BRIDGE_POSTED_WRITE_EN: write completion is signalled
// once AW and W are accepted, the B response is still awaited before the
// next request is taken.
module sram_like_axi_bridge
  import bridge_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input logic         clk,
  input logic         rst,
  sram_like_if.slave  sram,
  axi_if.master       axi
);

  state_e            r_state;
  state_e            w_next;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_aw_done;
  logic              r_w_done;

  logic       w_accept;
  logic [1:0] w_size_n;
  logic [3:0] w_wstrb;
  logic       w_aw_fire;
  logic       w_w_fire;
  logic       w_wr_both;
  logic       w_arvalid;
  logic       w_rready;
  logic       w_awvalid;
  logic       w_wvalid;
  logic       w_bready;
  logic       w_data_ok;
  logic       w_unused_in;

  assign w_accept = sram.data_req & (r_state == ST_IDLE);
  assign w_size_n = norm_size(sram.data_size);

  wstrb_gen u_wstrb_gen (
    .i_size    (w_size_n),
    .i_addr_lo (sram.data_addr[1:0]),
    .o_wstrb   (w_wstrb)
  );

  // Handshakes are derived from state and flags directly so that the
  // completion pulse does not loop back through the valid outputs.
  assign w_aw_fire = (r_state == ST_WR_REQ) & ~r_aw_done & axi.awready;
  assign w_w_fire  = (r_state == ST_WR_REQ) & ~r_w_done  & axi.wready;
  assign w_wr_both = (r_aw_done | w_aw_fire) & (r_w_done | w_w_fire);

  // State register; reset abandons whatever is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Capture the request only on the accept handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= 4'd0;
    end else if (w_accept) begin
      r_wr    <= sram.data_wr;
      r_size  <= w_size_n;
      r_addr  <= sram.data_addr;
      r_wdata <= sram.data_wdata;
      r_wstrb <= w_wstrb;
    end
  end

  // AW and W complete independently; both flags clear as WR_REQ is left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_state == ST_WR_REQ) begin
      if (w_wr_both) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_fire) r_aw_done <= 1'b1;
        if (w_w_fire)  r_w_done  <= 1'b1;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept)     w_next = sram.data_wr ? ST_WR_REQ : ST_RD_ADDR;
      ST_RD_ADDR: if (axi.arready)  w_next = ST_RD_DATA;
      ST_RD_DATA: if (axi.rvalid)   w_next = ST_IDLE;
      ST_WR_REQ:  if (w_wr_both)    w_next = ST_WR_RESP;
      ST_WR_RESP: if (axi.bvalid)   w_next = ST_IDLE;
      default:                      w_next = ST_IDLE;
    endcase
  end

  // Per-state handshake outputs and completion pulse.
  always_comb begin
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_bready  = 1'b0;
    w_data_ok = 1'b0;
    case (r_state)
      ST_RD_ADDR: w_arvalid = 1'b1;
      ST_RD_DATA: begin
        w_rready  = 1'b1;
        w_data_ok = axi.rvalid;
      end
      ST_WR_REQ: begin
        w_awvalid = ~r_aw_done;
        w_wvalid  = ~r_w_done;
`ifdef BRIDGE_POSTED_WRITE_EN
        w_data_ok = w_wr_both;
`endif
      end
      ST_WR_RESP: begin
        w_bready  = 1'b1;
`ifndef BRIDGE_POSTED_WRITE_EN
        w_data_ok = axi.bvalid;
`endif
      end
      default: ;
    endcase
  end

  assign sram.data_addr_ok = w_accept;
  assign sram.data_data_ok = w_data_ok;
  assign sram.data_rdata   = r_wr ? '0 : axi.rdata;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = r_addr;
  assign axi.arlen   = LEN_SINGLE;
  assign axi.arsize  = {1'b0, r_size};
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = w_arvalid;
  assign axi.rready  = w_rready;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = r_addr;
  assign axi.awlen   = LEN_SINGLE;
  assign axi.awsize  = {1'b0, r_size};
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = 2'd0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = w_awvalid;

  assign axi.wid     = AXI_ID;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = w_wvalid;
  assign axi.bready  = w_bready;

  // IDs, responses and rlast carry nothing this bridge acts on.
  assign w_unused_in = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Directed bench for sram_like_axi_bridge; honours BRIDGE_POSTED_WRITE_EN.
module tb_sram_like_axi_bridge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_like_if #(.ADDR_W(32), .DATA_W(32)) u_sram ();
  axi_if       #(.ADDR_W(32), .DATA_W(32)) u_axi ();

  sram_like_axi_bridge #(.ADDR_W(32), .DATA_W(32), .AXI_ID(4'd1)) dut (
    .clk  (clk),
    .rst  (rst),
    .sram (u_sram),
    .axi  (u_axi)
  );

`ifdef BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus monitor, sampled on the falling edge.
  int n_dok = 0, n_aok = 0, n_ar = 0, n_aw = 0, n_w = 0;
  int n_awdrop = 0, n_wdrop = 0, n_bent = 0;
  logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0, last_dok_rdata = '0;
  logic [2:0]  last_arsize = '0, last_awsize = '0;
  logic [3:0]  last_wstrb = '0;
  logic        last_wlast = 1'b0;
  logic        prev_awv = 1'b0, prev_wv = 1'b0, prev_br = 1'b0;

  always @(negedge clk) begin
    if (u_sram.data_data_ok) begin
      n_dok          <= n_dok + 1;
      last_dok_rdata <= u_sram.data_rdata;
    end
    if (u_sram.data_addr_ok) n_aok <= n_aok + 1;
    if (u_axi.arvalid && u_axi.arready) begin
      n_ar        <= n_ar + 1;
      last_araddr <= u_axi.araddr;
      last_arsize <= u_axi.arsize;
    end
    if (u_axi.awvalid && u_axi.awready) begin
      n_aw        <= n_aw + 1;
      last_awaddr <= u_axi.awaddr;
      last_awsize <= u_axi.awsize;
    end
    if (u_axi.wvalid && u_axi.wready) begin
      n_w        <= n_w + 1;
      last_wstrb <= u_axi.wstrb;
      last_wlast <= u_axi.wlast;
      last_wdata <= u_axi.wdata;
    end
    if (prev_awv && !u_axi.awvalid) n_awdrop <= n_awdrop + 1;
    if (prev_wv && !u_axi.wvalid)   n_wdrop  <= n_wdrop + 1;
    if (u_axi.bready && !prev_br)   n_bent   <= n_bent + 1;
    prev_awv <= u_axi.awvalid;
    prev_wv  <= u_axi.wvalid;
    prev_br  <= u_axi.bready;
  end

  int b_dok, b_aok, b_ar, b_aw, b_w, b_awdrop, b_wdrop, b_bent;

  task automatic snap();
    b_dok = n_dok; b_aok = n_aok; b_ar = n_ar; b_aw = n_aw; b_w = n_w;
    b_awdrop = n_awdrop; b_wdrop = n_wdrop; b_bent = n_bent;
  endtask

  task automatic chk_wr_counts(input string tag, input int d_dok);
    chk({tag, "_ndok"},   32'(n_dok - b_dok), 32'(d_dok));
    chk({tag, "_naw"},    32'(n_aw - b_aw), 32'd1);
    chk({tag, "_nw"},     32'(n_w - b_w), 32'd1);
    chk({tag, "_awdrop"}, 32'(n_awdrop - b_awdrop), 32'd1);
    chk({tag, "_wdrop"},  32'(n_wdrop - b_wdrop), 32'd1);
    chk({tag, "_bent"},   32'(n_bent - b_bent), 32'd1);
  endtask

  // Read after its accept: data inputs are scrambled while data_req stays
  // high, so any resampling would show up on araddr.
  task automatic rd_body(input int ar_dly, input int r_dly, input logic [31:0] rd, input string tag);
    int cyc;
    bit ok;
    u_sram.data_addr = 32'hFFFF_FFF0;
    u_sram.data_size = 2'd0;
    u_sram.data_wr   = 1'b1;
    cyc = 0; ok = 1'b0;
    while (!ok && cyc < 20) begin
      u_axi.arready = (cyc == ar_dly);
      #1;
      chk({tag, "_arvalid"}, 32'(u_axi.arvalid), 32'd1);
      chk({tag, "_aok_rd"},  32'(u_sram.data_addr_ok), 32'd0);
      ok = u_axi.arvalid && u_axi.arready;
      tick(); cyc++;
    end
    u_axi.arready = 1'b0;
    chk({tag, "_ar_done"}, 32'(ok), 32'd1);
    cyc = 0; ok = 1'b0;
    while (!ok && cyc < 20) begin
      u_axi.rvalid = (cyc == r_dly);
      u_axi.rdata  = (cyc == r_dly) ? rd : 32'h0BAD_0BAD;
      if (cyc == r_dly) u_sram.data_req = 1'b0;
      #1;
      chk({tag, "_rready"},  32'(u_axi.rready), 32'd1);
      chk({tag, "_arv_off"}, 32'(u_axi.arvalid), 32'd0);
      chk({tag, "_dok"},     32'(u_sram.data_data_ok), 32'(cyc == r_dly));
      if (cyc == r_dly) chk({tag, "_rdata"}, u_sram.data_rdata, rd);
      ok = u_axi.rvalid;
      tick(); cyc++;
    end
    u_axi.rvalid = 1'b0;
    chk({tag, "_r_done"}, 32'(ok), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input int ar_dly,
                         input int r_dly, input logic [31:0] rd, input string tag);
    u_sram.data_req  = 1'b1;
    u_sram.data_wr   = 1'b0;
    u_sram.data_size = sz;
    u_sram.data_addr = a;
    #1;
    chk({tag, "_aok"}, 32'(u_sram.data_addr_ok), 32'd1);
    tick();
    rd_body(ar_dly, r_dly, rd, tag);
  endtask

  // Write with per-channel ready delays; with hold_rd a read request is
  // presented during the response phase and must stay unaccepted.
  task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input bit hold_rd, input string tag);
    int cyc;
    bit aw_ok, w_ok, both, ok;
    u_sram.data_req   = 1'b1;
    u_sram.data_wr    = 1'b1;
    u_sram.data_size  = sz;
    u_sram.data_addr  = a;
    u_sram.data_wdata = wd;
    #1;
    chk({tag, "_aok"}, 32'(u_sram.data_addr_ok), 32'd1);
    tick();
    u_sram.data_req = 1'b0;
    cyc = 0; aw_ok = 1'b0; w_ok = 1'b0; both = 1'b0;
    while (!both && cyc < 20) begin
      u_axi.awready = (cyc == aw_dly);
      u_axi.wready  = (cyc == w_dly);
      #1;
      if (u_axi.awvalid && u_axi.awready) aw_ok = 1'b1;
      if (u_axi.wvalid && u_axi.wready)   w_ok  = 1'b1;
      both = aw_ok && w_ok;
      chk({tag, "_dok_req"},  32'(u_sram.data_data_ok), 32'(POSTED && both));
      chk({tag, "_bready0"}, 32'(u_axi.bready), 32'd0);
      tick(); cyc++;
    end
    u_axi.awready = 1'b0;
    u_axi.wready  = 1'b0;
    chk({tag, "_wr_done"}, 32'(both), 32'd1);
    if (hold_rd) begin
      u_sram.data_req  = 1'b1;
      u_sram.data_wr   = 1'b0;
      u_sram.data_size = 2'd2;
      u_sram.data_addr = 32'h0000_0600;
    end
    cyc = 0; ok = 1'b0;
    while (!ok && cyc < 20) begin
      u_axi.bvalid = (cyc == b_dly);
      #1;
      chk({tag, "_bready"},   32'(u_axi.bready), 32'd1);
      chk({tag, "_dok_resp"}, 32'(u_sram.data_data_ok), 32'(!POSTED && (cyc == b_dly)));
      chk({tag, "_aok_resp"}, 32'(u_sram.data_addr_ok), 32'd0);
      ok = u_axi.bvalid;
      tick(); cyc++;
    end
    u_axi.bvalid = 1'b0;
    chk({tag, "_b_done"}, 32'(ok), 32'd1);
  endtask

  // Back-to-back sequence tables.
  logic        seq_wr [3];
  logic [31:0] seq_a  [3];
  logic [31:0] rdv    [2];
  logic        dok_isrd [4];
  logic [31:0] dok_rd   [4];

  initial begin
    int idx, rd_srv, ndok;
    bit model_idle;
    u_sram.data_req = 1'b0; u_sram.data_wr = 1'b0; u_sram.data_size = 2'd0;
    u_sram.data_addr = '0; u_sram.data_wdata = '0;
    u_axi.arready = 1'b0; u_axi.rid = 4'd0; u_axi.rdata = '0; u_axi.rresp = 2'd0;
    u_axi.rlast = 1'b1; u_axi.rvalid = 1'b0; u_axi.awready = 1'b0; u_axi.wready = 1'b0;
    u_axi.bid = 4'd0; u_axi.bresp = 2'd0; u_axi.bvalid = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_arvalid", 32'(u_axi.arvalid), 32'd0);
    chk("rst_rready",  32'(u_axi.rready), 32'd0);
    chk("rst_awvalid", 32'(u_axi.awvalid), 32'd0);
    chk("rst_wvalid",  32'(u_axi.wvalid), 32'd0);
    chk("rst_bready",  32'(u_axi.bready), 32'd0);
    chk("rst_dok",     32'(u_sram.data_data_ok), 32'd0);
    chk("rst_aok",     32'(u_sram.data_addr_ok), 32'd0);
    rst = 1'b1;
    tick();

    // Word read, slow slave
    snap();
    do_read(32'h1000_0004, 2'd2, 2, 3, 32'hDEAD_BEEF, "t1");
    chk("t1_araddr", last_araddr, 32'h1000_0004);
    chk("t1_arsize", 32'(last_arsize), 32'd2);
    chk("t1_nar",    32'(n_ar - b_ar), 32'd1);
    chk("t1_ndok",   32'(n_dok - b_dok), 32'd1);
    chk("t1_naok",   32'(n_aok - b_aok), 32'd1);
    chk("t1_dokrd",  last_dok_rdata, 32'hDEAD_BEEF);

    // Byte write to lane 3
    snap();
    do_write(32'h0000_0003, 2'd0, 32'hAA00_0000, 0, 0, 2, 1'b0, "t2");
    chk_wr_counts("t2", 1);
    chk("t2_awaddr", last_awaddr, 32'h0000_0003);
    chk("t2_awsize", 32'(last_awsize), 32'd0);
    chk("t2_wstrb",  32'(last_wstrb), 32'h8);
    chk("t2_wlast",  32'(last_wlast), 32'd1);
    chk("t2_wdata",  last_wdata, 32'hAA00_0000);

    // Half writes: W first, AW first, together
    snap();
    do_write(32'h0000_0102, 2'd1, 32'h1234_0000, 3, 0, 0, 1'b0, "t3a");
    chk_wr_counts("t3a", 1);
    chk("t3a_wstrb",  32'(last_wstrb), 32'hC);
    chk("t3a_awsize", 32'(last_awsize), 32'd1);
    snap();
    do_write(32'h0000_0102, 2'd1, 32'h5678_0000, 0, 3, 1, 1'b0, "t3b");
    chk_wr_counts("t3b", 1);
    chk("t3b_wstrb",  32'(last_wstrb), 32'hC);
    snap();
    do_write(32'h0000_0102, 2'd1, 32'h9ABC_0000, 1, 1, 0, 1'b0, "t3c");
    chk_wr_counts("t3c", 1);
    chk("t3c_wstrb",  32'(last_wstrb), 32'hC);

    // Back-to-back read/write/read, zero-wait slave, data_req held
    seq_wr[0] = 1'b0; seq_a[0] = 32'h0000_0200;
    seq_wr[1] = 1'b1; seq_a[1] = 32'h0000_0204;
    seq_wr[2] = 1'b0; seq_a[2] = 32'h0000_0208;
    rdv[0] = 32'h1111_1111; rdv[1] = 32'h3333_3333;
    idx = 0; rd_srv = 0; ndok = 0; model_idle = 1'b1;
    for (int c = 0; c < 40 && ndok < 3; c++) begin
      u_sram.data_req   = (idx < 3);
      u_sram.data_wr    = (idx < 3) ? seq_wr[idx] : 1'b0;
      u_sram.data_addr  = (idx < 3) ? seq_a[idx] : 32'h0;
      u_sram.data_size  = 2'd2;
      u_sram.data_wdata = 32'h2222_2222;
      u_axi.arready = 1'b1;
      u_axi.awready = 1'b1;
      u_axi.wready  = 1'b1;
      u_axi.rvalid  = u_axi.rready;
      u_axi.rdata   = (u_axi.rready && rd_srv < 2) ? rdv[rd_srv] : 32'h0;
      u_axi.bvalid  = u_axi.bready;
      #1;
      chk("t4_aok", 32'(u_sram.data_addr_ok), 32'(u_sram.data_req && model_idle));
      if (u_sram.data_addr_ok) begin
        idx++;
        model_idle = 1'b0;
      end
      if (u_sram.data_data_ok && ndok < 4) begin
        dok_isrd[ndok] = u_axi.rready;
        dok_rd[ndok]   = u_sram.data_rdata;
        ndok++;
      end
      if ((u_axi.rvalid && u_axi.rready) || (u_axi.bvalid && u_axi.bready)) model_idle = 1'b1;
      if (u_axi.rvalid && u_axi.rready) rd_srv++;
      tick();
    end
    u_sram.data_req = 1'b0;
    u_axi.arready = 1'b0; u_axi.awready = 1'b0; u_axi.wready = 1'b0;
    u_axi.rvalid = 1'b0; u_axi.bvalid = 1'b0;
    chk("t4_ndok", 32'(ndok), 32'd3);
    if (ndok == 3) begin
      chk("t4_first_rd",  32'(dok_isrd[0]), 32'd1);
      chk("t4_second_wr", 32'(dok_isrd[1]), 32'd0);
      chk("t4_third_rd",  32'(dok_isrd[2]), 32'd1);
      chk("t4_rdata0", dok_rd[0], 32'h1111_1111);
      chk("t4_rdata2", dok_rd[2], 32'h3333_3333);
    end
    tick();

    // Reset while waiting for read data
    u_sram.data_req = 1'b1; u_sram.data_wr = 1'b0; u_sram.data_size = 2'd2;
    u_sram.data_addr = 32'h0000_0400;
    #1;
    chk("t5_aok", 32'(u_sram.data_addr_ok), 32'd1);
    tick();
    u_sram.data_req = 1'b0;
    u_axi.arready = 1'b1;
    #1;
    chk("t5_arvalid", 32'(u_axi.arvalid), 32'd1);
    tick();
    u_axi.arready = 1'b0;
    #1;
    chk("t5_rready_pre", 32'(u_axi.rready), 32'd1);
    rst = 1'b0;
    u_axi.rvalid = 1'b1;
    u_axi.rdata  = 32'hBAAD_F00D;
    #1;
    chk("t5_rready_rst", 32'(u_axi.rready), 32'd0);
    chk("t5_arv_rst",    32'(u_axi.arvalid), 32'd0);
    chk("t5_dok_rst",    32'(u_sram.data_data_ok), 32'd0);
    chk("t5_bready_rst", 32'(u_axi.bready), 32'd0);
    tick(); tick();
    u_axi.rvalid = 1'b0;
    rst = 1'b1;
    u_sram.data_req = 1'b1; u_sram.data_wr = 1'b0; u_sram.data_size = 2'd2;
    u_sram.data_addr = 32'h0000_0404;
    #1;
    chk("t5_aok_after", 32'(u_sram.data_addr_ok), 32'd1);
    tick();
    rd_body(1, 0, 32'hCAFE_F00D, "t5r");
    chk("t5_araddr", last_araddr, 32'h0000_0404);

    // Write with slow B, a read waiting behind it
    snap();
    do_write(32'h0000_0300, 2'd2, 32'h5A5A_5A5A, 0, 0, 5, 1'b1, "t6");
    chk("t6_wstrb", 32'(last_wstrb), 32'hF);
    #1;
    chk("t6_aok_after_b", 32'(u_sram.data_addr_ok), 32'd1);
    tick();
    rd_body(0, 1, 32'h600D_F00D, "t6r");
    chk("t6_araddr", last_araddr, 32'h0000_0600);
    chk("t6_ndok",   32'(n_dok - b_dok), 32'd2);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
